// File: rtl/taxi_dma_ram_rd_arb_if.sv
// Bus bundle for the DMA RAM read arbiter: requester-side (s_*) and RAM-side (m_*) handshakes.
// slave = the arbiter's view; master = the requesters plus RAM environment.
interface taxi_dma_ram_rd_arb_if #(
  parameter int PORTS  = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 128
);
  logic [PORTS*ADDR_W-1:0] s_rd_cmd_addr;
  logic [PORTS-1:0]        s_rd_cmd_valid;
  logic [PORTS-1:0]        s_rd_cmd_ready;
  logic [DATA_W-1:0]       s_rd_resp_data;
  logic [PORTS-1:0]        s_rd_resp_valid;
  logic [PORTS-1:0]        s_rd_resp_ready;
  logic [ADDR_W-1:0]       m_rd_cmd_addr;
  logic                    m_rd_cmd_valid;
  logic                    m_rd_cmd_ready;
  logic [DATA_W-1:0]       m_rd_resp_data;
  logic                    m_rd_resp_valid;
  logic                    m_rd_resp_ready;

  modport slave (
    input  s_rd_cmd_addr, s_rd_cmd_valid, s_rd_resp_ready,
           m_rd_cmd_ready, m_rd_resp_data, m_rd_resp_valid,
    output s_rd_cmd_ready, s_rd_resp_data, s_rd_resp_valid,
           m_rd_cmd_addr, m_rd_cmd_valid, m_rd_resp_ready
  );

  modport master (
    output s_rd_cmd_addr, s_rd_cmd_valid, s_rd_resp_ready,
           m_rd_cmd_ready, m_rd_resp_data, m_rd_resp_valid,
    input  s_rd_cmd_ready, s_rd_resp_data, s_rd_resp_valid,
           m_rd_cmd_addr, m_rd_cmd_valid, m_rd_resp_ready
  );
endinterface

// File: rtl/taxi_dma_ram_rd_arb.sv
// Round-robin arbiter sharing one in-order RAM read port among PORTS requesters.
// A tag FIFO remembers which port issued each read so responses route back in order.
module taxi_dma_ram_rd_arb #(
  parameter int PORTS  = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 128,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  taxi_dma_ram_rd_arb_if.slave     bus,
  output logic [$clog2(DEPTH):0]   outstanding
);
  localparam int PW = $clog2(PORTS);
  localparam int CW = $clog2(DEPTH);

  logic [PW-1:0]     last_grant_q, last_grant_d;
  logic [CW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW:0]       count_q, count_d;
  logic [PW-1:0]     tag_mem_q [DEPTH];

  logic [PW-1:0]     grant_idx, cand, head;
  logic              grant_vld, full, empty, cmd_hs, resp_hs;
  logic [ADDR_W-1:0] grant_addr;
  logic [DATA_W-1:0] resp_data;
  logic [PORTS-1:0]  cmd_ready, resp_valid;
  logic              resp_ready;

  assign full  = (count_q == (CW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = tag_mem_q[rd_ptr_q];

  // Search starts one past the last winner and wraps; a full FIFO blocks every port.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < PORTS; k++) begin
      cand = PW'((int'(last_grant_q) + 1 + k) % PORTS);
      if (!grant_vld && bus.s_rd_cmd_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    if (full || rst) grant_vld = 1'b0;
  end

  always_comb begin
    grant_addr = '0;
    cmd_ready  = '0;
    resp_valid = '0;
    resp_ready = 1'b0;
    for (int p = 0; p < PORTS; p++) begin
      if (grant_idx == PW'(p)) begin
        grant_addr   = bus.s_rd_cmd_addr[p*ADDR_W +: ADDR_W];
        cmd_ready[p] = grant_vld && bus.m_rd_cmd_ready;
      end
      if (head == PW'(p) && !empty && !rst) begin
        resp_valid[p] = bus.m_rd_resp_valid;
        resp_ready    = bus.s_rd_resp_ready[p];
      end
    end
  end

  assign resp_data           = bus.m_rd_resp_data;
  assign bus.s_rd_resp_data  = resp_data;
  assign bus.s_rd_cmd_ready  = cmd_ready;
  assign bus.s_rd_resp_valid = resp_valid;
  assign bus.m_rd_cmd_addr   = grant_addr;
  assign bus.m_rd_cmd_valid  = grant_vld;
  assign bus.m_rd_resp_ready = resp_ready;

  assign cmd_hs  = grant_vld && bus.m_rd_cmd_ready;
  assign resp_hs = bus.m_rd_resp_valid && resp_ready;

  always_comb begin
    wr_ptr_d     = wr_ptr_q + CW'(cmd_hs);
    rd_ptr_d     = rd_ptr_q + CW'(resp_hs);
    count_d      = count_q + (CW+1)'(cmd_hs) - (CW+1)'(resp_hs);
    last_grant_d = cmd_hs ? grant_idx : last_grant_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      last_grant_q <= PW'(PORTS-1);
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Tag storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clk) begin
    if (cmd_hs) tag_mem_q[wr_ptr_q] <= grant_idx;
  end

  assign outstanding = count_q;
endmodule

// File: tb/tb_taxi_dma_ram_rd_arb.sv
// Bench for taxi_dma_ram_rd_arb: arbitration table, in-order RAM model and routing scoreboard.
module tb_taxi_dma_ram_rd_arb;
  localparam int PORTS = 4, ADDR_W = 10, DATA_W = 128, DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] outstanding;

  taxi_dma_ram_rd_arb_if #(.PORTS(PORTS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  taxi_dma_ram_rd_arb #(.PORTS(PORTS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus), .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  typedef struct { logic [ADDR_W-1:0] addr; int due; } ram_t;
  typedef struct { int port; logic [ADDR_W-1:0] addr; } exp_t;
  typedef struct { logic [3:0] valid; logic [3:0] exp_ready; logic exp_mvalid; } vec_t;

  ram_t ram_q[$];
  exp_t exp_q[$];
  vec_t tbl[8];
  int   acnt[PORTS];
  int   n_tests = 0, n_fail = 0, cycle = 0, last_port = -1;
  bit   ram_en = 1'b0;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic int onehot_idx(logic [PORTS-1:0] v);
    int r = -1;
    if ($countones(v) != 1) return -1;
    for (int i = 0; i < PORTS; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic logic [ADDR_W-1:0] port_addr(int p);
    logic [1:0] pp = p[1:0];
    int         c  = acnt[p];
    return {pp, c[7:0]};
  endfunction

  function automatic logic [DATA_W-1:0] mkdata(logic [ADDR_W-1:0] a);
    return {8'hA5, 110'd0, a};
  endfunction

  task automatic set_addrs();
    for (int p = 0; p < PORTS; p++) bus.s_rd_cmd_addr[p*ADDR_W +: ADDR_W] = port_addr(p);
  endtask

  // RAM model: returns in command order, no earlier than 2 cycles after acceptance.
  task automatic ram_drive();
    if (ram_en && ram_q.size() > 0 && ram_q[0].due <= cycle) begin
      bus.m_rd_resp_valid = 1'b1;
      bus.m_rd_resp_data  = mkdata(ram_q[0].addr);
    end else begin
      bus.m_rd_resp_valid = 1'b0;
      bus.m_rd_resp_data  = '0;
    end
  endtask

  task automatic tick();
    int   p;
    exp_t e;
    ram_t r;
    @(negedge clk);
    last_port = -1;
    if (bus.m_rd_cmd_valid && bus.m_rd_cmd_ready) begin
      p = onehot_idx(bus.s_rd_cmd_ready);
      check("cmd_ready_onehot", 32'(p >= 0), 32'd1);
      if (p >= 0) begin
        check("cmd_addr", bus.m_rd_cmd_addr, port_addr(p));
        e.port = p; e.addr = port_addr(p);
        exp_q.push_back(e);
        r.addr = bus.m_rd_cmd_addr; r.due = cycle + 2;
        ram_q.push_back(r);
        last_port = p;
        acnt[p]++;
      end
    end
    if (bus.m_rd_resp_valid && bus.m_rd_resp_ready) begin
      p = onehot_idx(bus.s_rd_resp_valid);
      if (exp_q.size() == 0) begin
        check("resp_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("resp_port", 32'(p), 32'(e.port));
        check("resp_data", bus.s_rd_resp_data, mkdata(e.addr));
      end
      if (ram_q.size() > 0) void'(ram_q.pop_front());
    end
    @(posedge clk);
    #1;
    cycle++;
    set_addrs();
    ram_drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_outstanding", outstanding, 0);
    check("rst_cmd_valid", bus.m_rd_cmd_valid, 0);
    check("rst_cmd_ready", bus.s_rd_cmd_ready, 0);
    check("rst_resp_valid", bus.s_rd_resp_valid, 0);
    check("rst_resp_ready", bus.m_rd_resp_ready, 0);
    ram_q.delete();
    exp_q.delete();
    ram_en = 1'b0;
    bus.m_rd_resp_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic drain(string name);
    ram_en = 1'b1;
    ram_drive();
    for (int i = 0; i < 100 && !(outstanding == 0 && ram_q.size() == 0); i++) tick();
    check({name, "_outstanding"}, outstanding, 0);
    check({name, "_lost"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    tbl[0] = '{4'b1111, 4'b0001, 1'b1};
    tbl[1] = '{4'b1111, 4'b0010, 1'b1};
    tbl[2] = '{4'b0001, 4'b0001, 1'b1};
    tbl[3] = '{4'b1000, 4'b1000, 1'b1};
    tbl[4] = '{4'b0110, 4'b0010, 1'b1};
    tbl[5] = '{4'b0000, 4'b0000, 1'b0};
    tbl[6] = '{4'b0011, 4'b0001, 1'b1};
    tbl[7] = '{4'b1010, 4'b0010, 1'b1};
    for (int p = 0; p < PORTS; p++) acnt[p] = 0;

    bus.s_rd_cmd_valid  = 4'hF;
    bus.s_rd_resp_ready = 4'hF;
    bus.m_rd_cmd_ready  = 1'b1;
    bus.m_rd_resp_valid = 1'b1;
    bus.m_rd_resp_data  = '0;
    set_addrs();
    #1;
    do_reset();

    // Arbitration table, no responses returned
    for (int r = 0; r < 8; r++) begin
      bus.s_rd_cmd_valid = tbl[r].valid;
      #1;
      check("tbl_ready", bus.s_rd_cmd_ready, tbl[r].exp_ready);
      check("tbl_mvalid", bus.m_rd_cmd_valid, tbl[r].exp_mvalid);
      if (tbl[r].exp_mvalid) check("tbl_addr", bus.m_rd_cmd_addr, port_addr(onehot_idx(tbl[r].exp_ready)));
      tick();
    end
    bus.s_rd_cmd_valid = '0;
    check("tbl_outstanding", outstanding, 7);
    drain("tbl_drain");

    // Round-robin order with all ports valid and live RAM
    do_reset();
    ram_en = 1'b1;
    bus.s_rd_cmd_valid = 4'hF;
    for (int k = 0; k < 12; k++) begin
      tick();
      check("rr_order", 32'(last_port), 32'(k % 4));
    end
    bus.s_rd_cmd_valid = '0;
    drain("rr_drain");

    // Fill to DEPTH, then one pop frees exactly one grant
    do_reset();
    bus.s_rd_cmd_valid = 4'hF;
    repeat (10) tick();
    check("full_mvalid", bus.m_rd_cmd_valid, 0);
    check("full_outstanding", outstanding, 8);
    check("full_accepted", 32'(exp_q.size()), 32'd8);
    ram_en = 1'b1;
    ram_drive();
    ram_en = 1'b0;
    check("full_pop_ready", bus.m_rd_resp_ready, 1);
    check("full_pop_same_cycle", bus.m_rd_cmd_valid, 0);
    tick();
    check("pop_outstanding", outstanding, 7);
    check("pop_regrant", bus.m_rd_cmd_valid, 1);
    tick();
    check("refill_outstanding", outstanding, 8);
    check("refill_mvalid", bus.m_rd_cmd_valid, 0);
    bus.s_rd_cmd_valid = '0;
    drain("full_drain");

    // Head-of-line blocking by port 2
    do_reset();
    bus.s_rd_resp_ready = 4'b1011;
    bus.s_rd_cmd_valid  = 4'b0100;
    tick();
    bus.s_rd_cmd_valid  = 4'b0011;
    tick();
    tick();
    bus.s_rd_cmd_valid  = '0;
    ram_en = 1'b1;
    ram_drive();
    repeat (6) tick();
    check("hol_resp_ready", bus.m_rd_resp_ready, 0);
    check("hol_resp_valid", bus.s_rd_resp_valid, 4'b0100);
    check("hol_outstanding", outstanding, 3);
    bus.s_rd_resp_ready = 4'hF;
    drain("hol_drain");

    // Simultaneous accept and return at outstanding=3
    do_reset();
    bus.s_rd_cmd_valid = 4'b0001;
    repeat (3) tick();
    bus.s_rd_cmd_valid = 4'b0010;
    check("simul_pre", outstanding, 3);
    ram_en = 1'b1;
    ram_drive();
    check("simul_cmd_valid", bus.m_rd_cmd_valid, 1);
    check("simul_resp_ready", bus.m_rd_resp_ready, 1);
    tick();
    check("simul_outstanding", outstanding, 3);
    bus.s_rd_cmd_valid = '0;
    drain("simul_drain");

    // Reset with 5 in flight, then port 0 wins over port 3
    do_reset();
    bus.s_rd_cmd_valid = 4'hF;
    repeat (5) tick();
    bus.s_rd_cmd_valid = '0;
    check("mid_outstanding", outstanding, 5);
    bus.s_rd_cmd_valid = 4'b1001;
    do_reset();
    check("post_rst_ready", bus.s_rd_cmd_ready, 4'b0001);
    check("post_rst_addr", bus.m_rd_cmd_addr, port_addr(0));
    tick();
    bus.s_rd_cmd_valid = '0;
    drain("post_rst_drain");

    // Stray response with empty FIFO
    ram_en = 1'b0;
    bus.m_rd_resp_valid = 1'b1;
    bus.m_rd_resp_data  = mkdata(10'h3FF);
    #1;
    check("stray_resp_ready", bus.m_rd_resp_ready, 0);
    check("stray_resp_valid", bus.s_rd_resp_valid, 0);
    tick();
    check("stray_outstanding", outstanding, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end
endmodule
